// File: rtl/easy_fifo_pkg.sv
// Shared types and helpers for the easy_fifo write-side arbiter.
// Imported by the round-robin picker and the arbiter top.
package easy_fifo_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  function automatic int idw(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/easy_fifo_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at NUM_REQ.
module easy_fifo_rr_pick
  import easy_fifo_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = idw(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               any,
  output logic [IDW-1:0]     idx
);

  int d;
  int best;

  // d is the wrapped distance from ptr; smallest distance wins
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    d    = 0;
    best = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      d = i - int'(ptr);
      if (d < 0) d = d + NUM_REQ;
      if (req[i] && (d < best)) begin
        best = d;
        any  = 1'b1;
        idx  = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/easy_fifo_wr_arb.sv
// Round-robin burst-locking arbiter sharing one FIFO write port
// among NUM_REQ producers, optionally tagging words with source ID.
module easy_fifo_wr_arb
  import easy_fifo_pkg::*;
#(
  parameter int   NUM_REQ   = 4,
  parameter int   DWIDTH    = 32,
  parameter int   MAX_BURST = 8,
  parameter bit   TAG_EN    = 1'b1,
  localparam int  IDW       = idw(NUM_REQ),
  localparam int  FW        = DWIDTH + (TAG_EN ? IDW : 0)
) (
  input  logic                      wr_clk_int,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FW-1:0]             fifo_wr_data,
  output logic                      fifo_wr_en,
  input  logic                      fifo_wr_full,
  output logic [IDW-1:0]            grant_id,
  output logic                      busy
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   w_grant_nxt;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [IDW-1:0]   w_ptr_inc;
  logic [BCW-1:0]   r_beat;
  logic [BCW-1:0]   w_beat_nxt;

  logic             w_any;
  logic [IDW-1:0]   w_pick;
  logic             w_vld;
  logic             w_last;
  logic             w_acc;
  logic             w_cap;
  logic [DWIDTH-1:0] w_data;
  logic [NUM_REQ-1:0] w_onehot;

  easy_fifo_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .req (req_valid),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_pick)
  );

  always_comb begin
    w_data = '0;
    w_vld  = 1'b0;
    w_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_data = req_data[i*DWIDTH +: DWIDTH];
        w_vld  = req_valid[i];
        w_last = req_last[i];
      end
    end
  end

  assign w_onehot  = NUM_REQ'(1) << r_grant;
  assign w_cap     = (r_beat == BCW'(MAX_BURST - 1));
  // explicit wrap keeps the pointer legal for non-power-of-2 NUM_REQ
  assign w_ptr_inc = (r_grant == IDW'(NUM_REQ - 1)) ?
                     '0 : r_grant + IDW'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    w_acc       = 1'b0;
    req_ready   = '0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_any) begin
          w_state_nxt = ARB_LOCK;
          w_grant_nxt = w_pick;
          w_beat_nxt  = '0;
        end
      end
      ARB_LOCK: begin
        if (!fifo_wr_full) req_ready = w_onehot;
        w_acc = w_vld & ~fifo_wr_full;
        if (w_acc) begin
          w_beat_nxt = r_beat + BCW'(1);
          if (w_last || w_cap) begin
            w_state_nxt = ARB_IDLE;
            w_ptr_nxt   = w_ptr_inc;
          end
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk_int or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
      r_beat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  assign fifo_wr_en = w_acc;
  assign busy       = (r_state == ARB_LOCK);
  assign grant_id   = r_grant;

  generate
    if (TAG_EN) begin : g_tag
      assign fifo_wr_data = {r_grant, w_data};
    end else begin : g_notag
      assign fifo_wr_data = w_data;
    end
  endgenerate

endmodule

// File: tb/tb_easy_fifo_wr_arb.sv
// Bench for easy_fifo_wr_arb: per-cycle behavioural model plus
// directed scenarios and randomized traffic.
module tb_easy_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_last  = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]  req_ready;
  logic [33:0]   fifo_wr_data;
  logic          fifo_wr_en;
  logic          fifo_wr_full = 1'b0;
  logic [1:0]    grant_id;
  logic          busy;

  logic [2:0]    v3 = '0;
  logic [2:0]    l3 = '0;
  logic [95:0]   d3 = '0;
  logic [2:0]    rdy3;
  logic [31:0]   wd3;
  logic          we3;
  logic          full3 = 1'b0;
  logic [1:0]    g3;
  logic          busy3;

  always #5 clk = ~clk;

  easy_fifo_wr_arb #(
    .NUM_REQ(N), .DWIDTH(DW), .MAX_BURST(MB), .TAG_EN(1'b1)
  ) u_dut (
    .wr_clk_int   (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_last     (req_last),
    .req_ready    (req_ready),
    .fifo_wr_data (fifo_wr_data),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_full (fifo_wr_full),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  easy_fifo_wr_arb #(
    .NUM_REQ(3), .DWIDTH(32), .MAX_BURST(8), .TAG_EN(1'b0)
  ) u_dut3 (
    .wr_clk_int   (clk),
    .rst          (rst),
    .req_valid    (v3),
    .req_data     (d3),
    .req_last     (l3),
    .req_ready    (rdy3),
    .fifo_wr_data (wd3),
    .fifo_wr_en   (we3),
    .fifo_wr_full (full3),
    .grant_id     (g3),
    .busy         (busy3)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // producer queues and environment knobs
  bit [31:0] qd[N][$];
  bit        ql[N][$];
  int        gap_pct   = 0;
  int        full_pct  = 0;
  bit        fifo_mode = 0;
  int        fcnt      = 0;
  int        drain     = 0;
  logic [N-1:0] acc_mask = '0;
  bit        wr_seen   = 0;
  int        cyc       = 0;

  int        wl_tag[$];
  bit [31:0] wl_dat[$];
  int        wl_cyc[$];

  // reference model state
  bit        m_lock  = 0;
  int        m_g     = 0;
  int        m_ptr   = 0;
  int        m_beats = 0;
  int        m_j;
  bit        m_found;
  bit        e_en;
  logic [N-1:0] e_rdy;

  task automatic push_pkt(input int r, input int len,
                          input bit [31:0] base, input bit wl);
    for (int b = 0; b < len; b++) begin
      qd[r].push_back(base + b);
      ql[r].push_back(wl && (b == len - 1));
    end
  endtask

  function automatic bit qs_empty();
    for (int i = 0; i < N; i++)
      if (qd[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_empty(input string nm, input int budget);
    int c;
    c = 0;
    while (!qs_empty() && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (4) @(posedge clk);
    n_chk++;
    if (c < budget) n_pass++;
    else $display("FAIL %s: timeout after %0d cycles", nm, c);
  endtask

  // compare process: checks outputs and advances the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_lock = 0; m_g = 0; m_ptr = 0; m_beats = 0;
        acc_mask = '0;
        wr_seen  = 0;
        chk("rst_busy", busy, 0);
        chk("rst_wren", fifo_wr_en, 0);
        chk("rst_rdy", req_ready, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_data", fifo_wr_data, {2'b00, req_data[31:0]});
      end else begin
        e_rdy = '0;
        if (m_lock && !fifo_wr_full) e_rdy[m_g] = 1'b1;
        e_en = m_lock && req_valid[m_g] && !fifo_wr_full;
        chk("m_busy", busy, m_lock);
        chk("m_gid", grant_id, m_g);
        chk("m_rdy", req_ready, e_rdy);
        chk("m_wren", fifo_wr_en, e_en);
        chk("m_data", fifo_wr_data,
            {m_g[1:0], req_data[m_g*DW +: DW]});
        acc_mask = req_valid & req_ready;
        wr_seen  = fifo_wr_en;
        if (fifo_wr_en) begin
          wl_tag.push_back(int'(fifo_wr_data[33:32]));
          wl_dat.push_back(fifo_wr_data[31:0]);
          wl_cyc.push_back(cyc);
        end
        if (!m_lock) begin
          m_found = 0;
          for (int k = 0; k < N; k++) begin
            m_j = (m_ptr + k) % N;
            if (!m_found && req_valid[m_j]) begin
              m_found = 1; m_lock = 1; m_g = m_j; m_beats = 0;
            end
          end
        end else if (e_en) begin
          m_beats++;
          if (req_last[m_g] || m_beats == MB) begin
            m_lock = 0;
            m_ptr  = (m_g + 1) % N;
          end
        end
      end
    end
  end

  // producers and FIFO occupancy, updated just after each edge
  initial begin
    bit rd;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc_mask[i] && qd[i].size() > 0) begin
          void'(qd[i].pop_front());
          void'(ql[i].pop_front());
        end
      end
      for (int i = 0; i < N; i++) begin
        if (qd[i].size() > 0 &&
            $urandom_range(99) >= gap_pct) begin
          req_valid[i]           = 1'b1;
          req_data[i*DW +: DW]   = qd[i][0];
          req_last[i]            = ql[i][0];
        end else begin
          req_valid[i]           = 1'b0;
          req_data[i*DW +: DW]   = $urandom;
          req_last[i]            = 1'($urandom_range(1));
        end
      end
      if (fifo_mode) begin
        rd = (drain > 0) && (fcnt > 0);
        if (wr_seen) fcnt++;
        if (rd) begin
          fcnt--;
          drain--;
        end
        fifo_wr_full = (fcnt >= 4);
      end else begin
        fifo_wr_full = ($urandom_range(99) < full_pct);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bad;
    int cur;
    int runs[$];
    int sent;
    int r;
    int len;
    bit found;
    int c;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #3;
    chk("init_busy", busy, 0);
    chk("init_wren", fifo_wr_en, 0);
    chk("init_gid", grant_id, 0);

    // rotation: one single-beat packet per requester
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    for (int i = 0; i < N; i++) push_pkt(i, 1, 32'h100 + i, 1'b1);
    wait_empty("rot_wait", 100);
    chk("rot_n", wl_tag.size(), 4);
    for (int i = 0; i < 4 && i < wl_tag.size(); i++) begin
      chk("rot_tag", wl_tag[i], i);
      if (i > 0) chk("rot_gap", wl_cyc[i] - wl_cyc[i-1], 2);
    end
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    push_pkt(3, 1, 32'h333, 1'b1);
    push_pkt(0, 1, 32'h000, 1'b1);
    wait_empty("ptr0_wait", 100);
    chk("ptr0_n", wl_tag.size(), 2);
    if (wl_tag.size() == 2) begin
      chk("ptr0_first", wl_tag[0], 0);
      chk("ptr0_second", wl_tag[1], 3);
    end

    // burst cap: 20 beats without last
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    push_pkt(2, 20, 32'h2000, 1'b0);
    wait_empty("burst_wait", 200);
    chk("burst_n", wl_tag.size(), 20);
    bad = 0;
    for (int i = 0; i < wl_tag.size(); i++)
      if (wl_tag[i] != 2 || wl_dat[i] != 32'h2000 + i) bad++;
    chk("burst_content", bad, 0);
    runs.delete();
    cur = 1;
    for (int i = 1; i < wl_cyc.size(); i++) begin
      if (wl_cyc[i] == wl_cyc[i-1] + 1) cur++;
      else begin
        runs.push_back(cur);
        chk("burst_gap", wl_cyc[i] - wl_cyc[i-1], 2);
        cur = 1;
      end
    end
    runs.push_back(cur);
    chk("burst_runs", runs.size(), 3);
    if (runs.size() == 3) begin
      chk("burst_r0", runs[0], 8);
      chk("burst_r1", runs[1], 8);
      chk("burst_r2", runs[2], 4);
    end
    chk("burst_hold", busy, 1);
    push_pkt(2, 1, 32'h2014, 1'b1);
    wait_empty("burst_end", 50);

    // full backpressure with a depth-4 FIFO
    fifo_mode = 1; fcnt = 0; drain = 0;
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    push_pkt(1, 6, 32'h1000, 1'b1);
    repeat (20) @(posedge clk);
    #3;
    chk("bp_n4", wl_tag.size(), 4);
    chk("bp_full", fifo_wr_full, 1);
    chk("bp_rdy", req_ready, 0);
    chk("bp_busy", busy, 1);
    drain = 2;
    repeat (10) @(posedge clk);
    chk("bp_n6", wl_tag.size(), 6);
    bad = 0;
    for (int i = 0; i < wl_tag.size(); i++)
      if (wl_tag[i] != 1 || wl_dat[i] != 32'h1000 + i) bad++;
    chk("bp_content", bad, 0);
    chk("bp_q", qd[1].size(), 0);
    drain = 100;
    repeat (6) @(posedge clk);
    fifo_mode = 0; fcnt = 0; drain = 0;

    // fairness: two requesters with 3-beat packets
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    for (int p = 0; p < 4; p++) begin
      push_pkt(0, 3, 32'h3000 + p * 16, 1'b1);
      push_pkt(3, 3, 32'h4000 + p * 16, 1'b1);
    end
    wait_empty("fair_wait", 200);
    chk("fair_n", wl_tag.size(), 24);
    bad = 0;
    for (int i = 0; i < wl_tag.size(); i++)
      if (wl_tag[i] != (((i / 3) % 2 == 0) ? 3 : 0)) bad++;
    chk("fair_order", bad, 0);

    // asynchronous reset during beat 3 of a 5-beat packet
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    push_pkt(1, 5, 32'h5000, 1'b1);
    found = 0;
    c = 0;
    while (!found && c < 50) begin
      @(posedge clk);
      #3;
      c++;
      if (wl_tag.size() == 2 && fifo_wr_en) found = 1;
    end
    chk("ar_reach", found, 1);
    rst = 1'b1;
    #1;
    chk("ar_wren", fifo_wr_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_gid", grant_id, 0);
    for (int i = 0; i < N; i++) begin
      qd[i].delete();
      ql[i].delete();
    end
    push_pkt(3, 1, 32'h7003, 1'b1);
    push_pkt(2, 1, 32'h7002, 1'b1);
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    wait_empty("ar_wait", 100);
    chk("ar_n", wl_tag.size(), 2);
    if (wl_tag.size() == 2) begin
      chk("ar_first", wl_tag[0], 2);
      chk("ar_first_d", wl_dat[0], 32'h7002);
    end

    // randomized traffic with gaps and full
    gap_pct = 25; full_pct = 20; sent = 0;
    wl_tag.delete(); wl_dat.delete(); wl_cyc.delete();
    repeat (60) begin
      r   = $urandom_range(N - 1);
      len = $urandom_range(12, 1);
      push_pkt(r, len, $urandom, 1'b1);
      sent += len;
      repeat ($urandom_range(15)) @(posedge clk);
    end
    wait_empty("rand_wait", 8000);
    chk("rand_cnt", wl_tag.size(), sent);
    gap_pct = 0; full_pct = 0;

    // untagged three-requester instance
    @(posedge clk);
    #1;
    v3 = 3'b100; l3 = 3'b100;
    d3[95:64] = 32'hA5A5_0001;
    @(posedge clk);
    #1;
    chk("t3_busy", busy3, 1);
    chk("t3_gid", g3, 2);
    chk("t3_wren", we3, 1);
    chk("t3_data", wd3, 32'hA5A5_0001);
    chk("t3_rdy", rdy3, 3'b100);
    @(posedge clk);
    #1;
    chk("t3_idle", busy3, 0);
    v3 = 3'b011; l3 = 3'b011;
    d3 = {32'h0, 32'h1111_0001, 32'h0000_0abc};
    @(posedge clk);
    #1;
    chk("t3_wrap", g3, 0);
    chk("t3_wrap_d", wd3, 32'h0000_0abc);
    v3 = '0; l3 = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/easy_fifo_wr_arb.md
# easy_fifo_wr_arb

Round-robin write arbiter that shares one synchronous FIFO write port among `NUM_REQ` independent producers. It sits directly in front of `easy_fifo_sync` on the write clock domain. Each requester gets a locked burst of up to `MAX_BURST` beats, or up to its `last` beat. Words are optionally tagged with the source index so the read side can demultiplex.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DWIDTH`, 32: payload width per requester.
- `MAX_BURST`, 8: maximum beats per grant, ≥1.
- `TAG_EN`, 1: 1 prepends the source ID to each FIFO word; 0 writes the payload only.
- Derived `IDW` = max(1, $clog2(NUM_REQ)). Derived `FW` = DWIDTH + (TAG_EN ? IDW : 0).

Ports:
- `wr_clk_int`  in  1  clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester beat valid.
- `req_data`  in  NUM_REQ×DWIDTH  per-requester payload.
- `req_last`  in  NUM_REQ  marks the final beat of a requester's packet.
- `req_ready`  out  NUM_REQ  beat accepted this cycle when paired with valid.
- `fifo_wr_data`  out  FW  to FIFO `wr_data`; equals {grant_id, data} when TAG_EN=1.
- `fifo_wr_en`  out  1  to FIFO `wr_en`.
- `fifo_wr_full`  in  1  from FIFO `wr_full`.
- `grant_id`  out  IDW  currently or last granted requester.
- `busy`  out  1  high while in ARB_LOCK.

## Operation
- FSM has two states: ARB_IDLE and ARB_LOCK.
- **ARB_IDLE:** if any `req_valid` is set, select the first set bit scanning from `rr_ptr` upward with wrap. Register it into `grant_id`, clear `beat_cnt`, and go to ARB_LOCK. Otherwise stay. No transfers occur in IDLE.
- **ARB_LOCK:**
  - `req_ready[grant_id]` = !fifo_wr_full. All other `req_ready` bits are 0.
  - `fifo_wr_en` = req_valid[grant_id] & !fifo_wr_full.
  - `fifo_wr_data` muxes `req_data[grant_id]`.
  - Each accepted beat increments `beat_cnt`.
- **Release:** on an accepted beat with `req_last[grant_id]`=1, or on an accepted beat where `beat_cnt` reaches MAX_BURST-1, go to ARB_IDLE and set `rr_ptr` = grant_id+1 mod NUM_REQ.
- **Gaps:** the grant is held across gaps in `req_valid[grant_id]`. There is no timeout; a requester must finish its packet.
- **Widths:** `beat_cnt` is $clog2(MAX_BURST+1) bits. `rr_ptr` is IDW bits, wrapped explicitly at NUM_REQ when NUM_REQ is not a power of 2.
- **FIFO full:** `fifo_wr_en` and `req_ready` are forced to 0. State, `beat_cnt` and `grant_id` are held.
- **Reset values:**
  - State ARB_IDLE; `rr_ptr`=0, `grant_id`=0, `beat_cnt`=0.
  - `fifo_wr_en`=0, `req_ready`=0, `busy`=0.
  - `fifo_wr_data` = {0, req_data[0]}: mux follows `grant_id`, and no write is issued.
- **Reset mid-burst:** state returns to IDLE immediately (asynchronous). The partial packet is abandoned; no further beats are written.

## Timing
- Arbitration costs exactly 1 cycle: a valid seen in IDLE at edge N gives `busy`=1 and a possible first write in cycle N+1.
- Write path is combinational from state and `fifo_wr_full` to `fifo_wr_en` and `req_ready`: zero added latency, one beat per cycle in LOCK.
- Release is followed by one IDLE cycle, so back-to-back single-beat packets run at 50% throughput. A full MAX_BURST run achieves MAX_BURST/(MAX_BURST+1).
- Simultaneous last-beat and MAX_BURST: a single release, no double pointer advance.
- `fifo_wr_full` rising in the same cycle as a beat: the beat is not accepted; the requester retries.

## Structure
- **Package `easy_fifo_pkg`:**
  - enum `arb_state_t` {ARB_IDLE, ARB_LOCK}.
  - function `idw(n)` returning max(1, $clog2(n)).
- **Sub-module `easy_fifo_rr_pick`:** combinational, inputs `req[NUM_REQ]` and `ptr`; outputs `any` and `idx`. It is reused by future read-side schedulers.
- **Top:** FSM, counters, data mux and tag concatenation live in `easy_fifo_wr_arb`.

## Test plan
- **Rotation:** reset, then all four requesters assert valid with last=1 on one beat each → FIFO receives tags 0,1,2,3 in order, one write every 2 cycles; `rr_ptr` returns to 0.
- **Burst cap:** MAX_BURST=8, requester 2 streams 20 beats with no last, requester 3 idle → writes of 8, 8, 4 beats, each run tagged 2, separated by single IDLE cycles.
- **Full backpressure:** FIFO depth 4, requester 1 sends 6 beats, read side stalled → exactly 4 writes, `req_ready[1]`=0 while full. Draining 2 entries lets beats 5 and 6 proceed with no duplication or loss.
- **Fairness under contention:** requesters 0 and 3 continuously send 3-beat packets → grants alternate 0,3,0,3; neither waits more than one packet.
- **Async reset mid-burst:** assert `rst` during beat 3 of a 5-beat packet → `fifo_wr_en` is 0 in the same cycle, `busy`=0, `grant_id`=0. After release, the first grant goes to the lowest-index valid requester.
- **TAG_EN=0, NUM_REQ=3:** data 0xA5A5_0001 from requester 2 → `fifo_wr_data`=0xA5A5_0001, width 32. The pointer wraps 2→0.
